level_param_sequencer: RTL and testbench

Consumes the difficulty handshake (one-hot `level` plus sticky `end_signal`) from the keypad level-selection stage. Decodes the level into a speed multiplier and an object count, then runs the spawn schedule: one `spawn_tick` per period until the level's object count is reached. Sits between level selection and the object/game logic, as the receiving end of the level handshake.

---
 rtl/level_pkg.sv | 42 ++++
 rtl/spawn_timer.sv | 38 +++
 rtl/level_param_sequencer.sv | 135 +++++++++++++
 tb/tb_level_param_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/level_pkg.sv
// Shared constants for the level sequencer: level codes, per-level speed,
// object count and period shift, plus the sequencer state encoding.
package level_pkg;

    localparam logic [2:0] LVL_EASY = 3'b001;
    localparam logic [2:0] LVL_MID  = 3'b010;
    localparam logic [2:0] LVL_HARD = 3'b100;

    localparam logic [2:0] SPEED_EASY = 3'd1;
    localparam logic [2:0] SPEED_MID  = 3'd2;
    localparam logic [2:0] SPEED_HARD = 3'd4;

    localparam int unsigned COUNT_EASY = 8;
    localparam int unsigned COUNT_MID  = 12;
    localparam int unsigned COUNT_HARD = 16;

    // Period = base >> shift, so the speed multiplier is 1 << shift.
    localparam logic [1:0] SHIFT_EASY = 2'd0;
    localparam logic [1:0] SHIFT_MID  = 2'd1;
    localparam logic [1:0] SHIFT_HARD = 2'd2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        RUN   = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_e;

    function automatic logic level_valid(input logic [2:0] lvl);
        return (lvl == LVL_EASY) || (lvl == LVL_MID) || (lvl == LVL_HARD);
    endfunction

    function automatic logic [1:0] level_shift(input logic [2:0] lvl);
        case (lvl)
            LVL_MID:  return SHIFT_MID;
            LVL_HARD: return SHIFT_HARD;
            default:  return SHIFT_EASY;
        endcase
    endfunction

endpackage

// File: rtl/spawn_timer.sv
// Loadable period counter. `tick` is the combinational terminal-count flag
// (count == period-1 while enabled); the counter wraps to 0 on it.
module spawn_timer #(
    parameter int unsigned TICK_DIV_BASE = 1000,
    localparam int unsigned CW = $clog2(TICK_DIV_BASE),
    localparam int unsigned PW = CW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [PW-1:0] period,
    input  logic          en,
    output logic          tick
);

    logic [CW-1:0] cnt_q;
    logic [PW-1:0] period_q;

    assign tick = en && ({1'b0, cnt_q} == (period_q - PW'(1)));

    // Load latches the period and restarts from 0; otherwise count while enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            period_q <= '0;
        end else if (load) begin
            cnt_q    <= '0;
            period_q <= period;
        end else if (en) begin
            if (tick) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/level_param_sequencer.sv
// Level handshake receiver and spawn scheduler. A rising edge on end_signal
// captures the one-hot level, which is decoded into speed/object count; one
// registered spawn_tick is then issued per period until the count is reached.
// Optional build macro LEVEL_SEQ_PAUSE_EN adds a `pause` input that stalls RUN.
module level_param_sequencer
    import level_pkg::*;
#(
    parameter int unsigned TICK_DIV_BASE = 1000,
    parameter int unsigned CNT_W         = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       level,
    input  logic             end_signal,
`ifdef LEVEL_SEQ_PAUSE_EN
    input  logic             pause,
`endif
    output logic [2:0]       speed_mult,
    output logic [CNT_W-1:0] obj_total,
    output logic             spawn_tick,
    output logic [CNT_W-1:0] spawned_cnt,
    output logic             busy,
    output logic             game_done,
    output logic             level_err
);

    localparam int unsigned CW = $clog2(TICK_DIV_BASE);
    localparam int unsigned PW = CW + 1;
    localparam logic [PW-1:0] BASE_PERIOD = PW'(TICK_DIV_BASE);

    state_e        state_q;
    logic          end_prev_q;
    logic [2:0]    lvl_q;
    logic          start;
    logic          stall;
    logic          run_en;
    logic          tmr_load;
    logic          tmr_tick;
    logic [PW-1:0] period;

    assign start = end_signal && !end_prev_q;

`ifdef LEVEL_SEQ_PAUSE_EN
    assign stall = pause;
`else
    assign stall = 1'b0;
`endif

    assign run_en   = (state_q == RUN) && !stall;
    assign tmr_load = (state_q == CHECK);

    // Period for the captured level; only consumed by the timer in CHECK.
    always_comb begin
        period = BASE_PERIOD >> level_shift(lvl_q);
    end

    spawn_timer #(
        .TICK_DIV_BASE(TICK_DIV_BASE)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .period (period),
        .en     (run_en),
        .tick   (tmr_tick)
    );

    // Sequencer FSM with registered outputs; DONE and ERR hold until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            end_prev_q  <= 1'b0;
            lvl_q       <= '0;
            speed_mult  <= '0;
            obj_total   <= '0;
            spawn_tick  <= 1'b0;
            spawned_cnt <= '0;
            busy        <= 1'b0;
            game_done   <= 1'b0;
            level_err   <= 1'b0;
        end else begin
            end_prev_q <= end_signal;
            spawn_tick <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        lvl_q   <= level;
                        busy    <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    case (lvl_q)
                        LVL_EASY: begin
                            speed_mult <= SPEED_EASY;
                            obj_total  <= CNT_W'(COUNT_EASY);
                        end
                        LVL_MID: begin
                            speed_mult <= SPEED_MID;
                            obj_total  <= CNT_W'(COUNT_MID);
                        end
                        LVL_HARD: begin
                            speed_mult <= SPEED_HARD;
                            obj_total  <= CNT_W'(COUNT_HARD);
                        end
                        default: ;
                    endcase
                    if (level_valid(lvl_q)) begin
                        spawned_cnt <= '0;
                        state_q     <= RUN;
                    end else begin
                        busy      <= 1'b0;
                        level_err <= 1'b1;
                        state_q   <= ERR;
                    end
                end
                RUN: begin
                    if (tmr_tick) begin
                        spawn_tick  <= 1'b1;
                        spawned_cnt <= spawned_cnt + CNT_W'(1);
                        if ((spawned_cnt + CNT_W'(1)) == obj_total) begin
                            busy      <= 1'b0;
                            game_done <= 1'b1;
                            state_q   <= DONE;
                        end
                    end
                end
                DONE: ;
                ERR:  ;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_level_param_sequencer.sv
// Bench for level_param_sequencer (TICK_DIV_BASE=8). A timeline model derives
// expected outputs from the number of un-paused RUN cycles since decode.
module tb_level_param_sequencer;

    localparam int unsigned TDB = 8;
    localparam int unsigned CW  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    level = 3'b000;
    logic          end_signal = 1'b0;
    logic          pause = 1'b0;
    logic [2:0]    speed_mult;
    logic [CW-1:0] obj_total;
    logic          spawn_tick;
    logic [CW-1:0] spawned_cnt;
    logic          busy;
    logic          game_done;
    logic          level_err;

    int checks = 0;
    int failures = 0;
    int tick_total = 0;

    always #5 clk = ~clk;

    level_param_sequencer #(
        .TICK_DIV_BASE(TDB),
        .CNT_W(CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .level       (level),
        .end_signal  (end_signal),
`ifdef LEVEL_SEQ_PAUSE_EN
        .pause       (pause),
`endif
        .speed_mult  (speed_mult),
        .obj_total   (obj_total),
        .spawn_tick  (spawn_tick),
        .spawned_cnt (spawned_cnt),
        .busy        (busy),
        .game_done   (game_done),
        .level_err   (level_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a start edge opens a one-cycle decode window, after
    // which ticks land every `period` active cycles, capped at the total.
    int m_prev_end, m_started, m_in_check, m_run, m_err;
    int m_speed, m_total, m_period, m_active, m_ticks;
    bit m_start, m_step;
    logic [2:0] m_lvl;
    int exp_speed = 0, exp_total = 0, exp_tick = 0, exp_cnt = 0;
    int exp_busy = 0, exp_done = 0, exp_err = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_prev_end = 0; m_started = 0; m_in_check = 0; m_run = 0; m_err = 0;
            m_speed = 0; m_total = 0; m_period = 1; m_active = 0; m_step = 0;
        end else begin
            m_start = (end_signal === 1'b1) && (m_prev_end == 0);
            m_prev_end = (end_signal === 1'b1) ? 1 : 0;
            m_step = 0;
            if (m_run != 0) begin
                if (pause !== 1'b1) begin
                    m_active++;
                    m_step = 1;
                end
            end else if (m_in_check != 0) begin
                m_in_check = 0;
                if (m_lvl == 3'b001) begin m_speed = 1; m_total = 8; end
                else if (m_lvl == 3'b010) begin m_speed = 2; m_total = 12; end
                else if (m_lvl == 3'b100) begin m_speed = 4; m_total = 16; end
                else m_err = 1;
                if (m_err == 0) begin
                    m_run = 1;
                    m_period = TDB / m_speed;
                    m_active = 0;
                end
            end else if (m_started == 0 && m_start) begin
                m_started = 1;
                m_in_check = 1;
                m_lvl = level;
            end
        end
        m_ticks   = (m_run != 0) ? m_active / m_period : 0;
        exp_cnt   = (m_ticks < m_total) ? m_ticks : m_total;
        exp_tick  = (m_step && m_active % m_period == 0 && m_ticks <= m_total) ? 1 : 0;
        exp_done  = (m_run != 0 && m_ticks >= m_total) ? 1 : 0;
        exp_busy  = (m_in_check != 0 || (m_run != 0 && exp_done == 0)) ? 1 : 0;
        exp_speed = m_speed;
        exp_total = m_total;
        exp_err   = m_err;
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        check("speed_mult", 32'(speed_mult), 32'(exp_speed));
        check("obj_total", 32'(obj_total), 32'(exp_total));
        check("spawn_tick", 32'(spawn_tick), 32'(exp_tick));
        check("spawned_cnt", 32'(spawned_cnt), 32'(exp_cnt));
        check("busy", 32'(busy), 32'(exp_busy));
        check("game_done", 32'(game_done), 32'(exp_done));
        check("level_err", 32'(level_err), 32'(exp_err));
        if (spawn_tick === 1'b1) tick_total++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        end_signal = 1'b0;
        level = 3'b000;
        pause = 1'b0;
        @(negedge clk);
        #1;
        check("rst_speed", 32'(speed_mult), 0);
        check("rst_total", 32'(obj_total), 0);
        check("rst_cnt", 32'(spawned_cnt), 0);
        check("rst_flags", {28'd0, busy, game_done, level_err, spawn_tick}, 0);
        #1;
        rst = 1'b1;
    endtask

    // Returns at negedge+1 once k more ticks were seen, or when the budget expires.
    task automatic wait_ticks(input int k, input int budget, input string name);
        int base;
        int n;
        base = tick_total;
        n = 0;
        while ((tick_total - base) < k && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 32'(tick_total - base), 32'(k));
    endtask

    // Cycles (negedges) until spawn_tick is seen, bounded.
    task automatic cycles_to_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (spawn_tick !== 1'b1 && n < 64);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        logic [2:0] lvl;

        #1 rst = 1'b0;

        // Easy: latency of decode and first tick, total 8, sticky done.
        do_reset();
        level = 3'b001;
        cycles(int'($urandom_range(0, 3)));
        base = tick_total;
        end_signal = 1'b1;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (busy !== 1'b1 && n < 10);
        check("check_latency", 32'(n), 1);
        cycles_to_tick(n);
        check("first_tick_latency", 32'(n), 9);
        cycles_to_tick(n);
        check("easy_period", 32'(n), 8);
        cycles(70);
        check("easy_speed", 32'(speed_mult), 1);
        check("easy_total", 32'(obj_total), 8);
        check("easy_cnt", 32'(spawned_cnt), 8);
        check("easy_done", {30'd0, game_done, busy}, 32'b10);
        check("easy_ticks", 32'(tick_total - base), 8);
        check("model_easy_cnt", 32'(exp_cnt), 8);
        end_signal = 1'b0;
        cycles(3);
        end_signal = 1'b1;
        cycles(20);
        check("easy_restart_ignored", 32'(tick_total - base), 8);

        // Hard: period 2, total 16, no 17th tick.
        do_reset();
        level = 3'b100;
        base = tick_total;
        end_signal = 1'b1;
        wait_ticks(1, 20, "hard_first_tick");
        cycles_to_tick(n);
        check("hard_period", 32'(n), 2);
        cycles(50);
        check("hard_speed", 32'(speed_mult), 4);
        check("hard_total", 32'(obj_total), 16);
        check("hard_cnt", 32'(spawned_cnt), 16);
        check("hard_ticks", 32'(tick_total - base), 16);
        check("model_hard_done", 32'(exp_done), 1);

        // Multi-hot level: error, sticky through another start edge.
        do_reset();
        level = 3'b011;
        base = tick_total;
        end_signal = 1'b1;
        cycles(15);
        end_signal = 1'b0;
        cycles(3);
        level = 3'b001;
        end_signal = 1'b1;
        cycles(15);
        check("err_flag", 32'(level_err), 1);
        check("err_speed", 32'(speed_mult), 0);
        check("err_total", 32'(obj_total), 0);
        check("err_ticks", 32'(tick_total - base), 0);
        check("model_err", 32'(exp_err), 1);

        // Mid with level flipped mid-run: period stays 4, total stays 12.
        do_reset();
        level = 3'b010;
        base = tick_total;
        end_signal = 1'b1;
        wait_ticks(3, 40, "mid_three_ticks");
        level = 3'b100;
        cycles_to_tick(n);
        check("mid_period_after_flip", 32'(n), 4);
        wait_ticks(8, 60, "mid_remaining_ticks");
        cycles(10);
        check("mid_total", 32'(obj_total), 12);
        check("mid_speed", 32'(speed_mult), 2);
        check("mid_cnt", 32'(spawned_cnt), 12);
        check("mid_ticks", 32'(tick_total - base), 12);

        // Reset mid-run with end_signal held: clears at once, restarts from 0.
        do_reset();
        level = 3'b010;
        end_signal = 1'b1;
        wait_ticks(5, 40, "rst_mid_five_ticks");
        rst = 1'b0;
        #1;
        check("rst_mid_cnt", 32'(spawned_cnt), 0);
        check("rst_mid_total", 32'(obj_total), 0);
        check("rst_mid_flags", {29'd0, busy, game_done, spawn_tick}, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        wait_ticks(1, 20, "rst_mid_restart_tick");
        check("rst_mid_restart_cnt", 32'(spawned_cnt), 1);
        wait_ticks(11, 80, "rst_mid_rest");
        cycles(3);
        check("rst_mid_done", 32'(game_done), 1);

`ifdef LEVEL_SEQ_PAUSE_EN
        // Pause at counter 5 for 20 cycles, next tick 3 cycles after release.
        do_reset();
        level = 3'b001;
        end_signal = 1'b1;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (busy !== 1'b1 && n < 10);
        repeat (6) @(negedge clk);
        #1;
        base = tick_total;
        pause = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("pause_no_tick", 32'(tick_total - base), 0);
        pause = 1'b0;
        cycles_to_tick(n);
        check("pause_resume_tick", 32'(n), 3);
`endif

        // Randomized runs with level noise, end_signal toggles and pauses.
        for (int it = 0; it < 8; it++) begin
            do_reset();
            n = int'($urandom_range(0, 4));
            if (n < 3) lvl = 3'b001 << n;
            else lvl = 3'($urandom_range(0, 7));
            level = lvl;
            cycles(int'($urandom_range(0, 5)));
            end_signal = 1'b1;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                #2;
                if ($urandom_range(0, 9) == 0) level = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 15) == 0) end_signal = ~end_signal;
`ifdef LEVEL_SEQ_PAUSE_EN
                pause = ($urandom_range(0, 5) == 0);
`endif
            end
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
